truth_table_scanner: RTL and testbench
======================================

# truth_table_scanner

Sequential exerciser that sits directly upstream and downstream of the team's 4-input combinational logic blocks (inputs A, B, C, D; output F). On `start` it drives every input vector 0..2^N_IN-1 onto the logic block and waits a programmable settle time. It then samples F back into a captured truth table and compares it against an expected mask. It replaces manual sweeps with a self-checking, clocked scan that reports pass/fail, a mismatch count and the first failing vector.

## Interface

- `N_IN`, 4: number of logic-block inputs; the table has 2^N_IN entries.
- `SETTLE`, 1: cycles between driving a vector and sampling F. Legal range is 1..15.
- `EXPECTED`, 16'h0222: golden truth table; bit k is the expected F for vector k. The default is F = ~(A&B | C) & D with A as the MSB.

- `clk` in 1: the only clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a scan; sampled only in IDLE.
- `vec` out N_IN: drives the logic-block inputs as {A,B,C,D}, A = MSB.
- `f_in` in 1: output F of the logic block.
- `busy` out 1: high from the cycle after `start` is accepted until the end of the DONE cycle.
- `done` out 1: single-cycle pulse when the scan completes.
- `pass` out 1: 1 when the captured table equals `EXPECTED`; valid from `done` until the next accepted `start`.
- `table_out` out 2^N_IN: captured truth table; bit k is the F sampled for vector k.
- `mismatch_cnt` out N_IN+1: number of vectors where `f_in` != `EXPECTED[k]` (0..16).
- `first_fail` out N_IN: lowest failing vector index.
- `first_fail_valid` out 1: high if at least one mismatch was recorded.

## Operation

- **States.** The FSM has four states:
  - IDLE: `busy`=0.
  - WAIT: settle counter running.
  - SAMPLE: capture and compare.
  - DONE: one cycle only.
- **Transitions.**
  - IDLE -> WAIT when `start`=1. At that edge: `vec`<=0, settle counter<=0, `table_out`<=0, `mismatch_cnt`<=0, `first_fail_valid`<=0, `first_fail`<=0, `pass`<=0.
  - WAIT -> SAMPLE when the settle counter reaches SETTLE-1. Otherwise WAIT holds and the counter increments.
  - SAMPLE, at its edge:
    - `table_out[vec]`<=`f_in`.
    - On mismatch, `mismatch_cnt`+=1.
    - On a mismatch with `first_fail_valid`=0, `first_fail`<=`vec` and `first_fail_valid`<=1.
  - SAMPLE -> WAIT with `vec`+=1 and counter cleared, if `vec` != 2^N_IN-1.
  - SAMPLE -> DONE if `vec` == 2^N_IN-1. At this edge `pass`<=1 iff the final mismatch count is 0, including the current vector.
  - DONE -> IDLE unconditionally.
- **`vec` behaviour.** `vec` holds its last value (2^N_IN-1) after the scan. It does not wrap to 0 until the next accepted `start`.
- **`start` handling.** `start` is ignored in WAIT, SAMPLE and DONE. A `start` arriving in DONE does not queue.
- **Arithmetic.** `mismatch_cnt` is N_IN+1 bits wide and cannot overflow at 16. The `vec` increment is N_IN bits wide.
- **Reset.** Asynchronous `rst` at any time forces:
  - state IDLE;
  - `vec`, `table_out`, `mismatch_cnt`, `first_fail`, `first_fail_valid`, `pass`, `busy`, `done` all to 0.
- **Reset mid-scan.** This aborts the scan: no `done` pulse, and results are cleared.

## Timing

- **Start acceptance.** `start`=1 in IDLE during cycle t is accepted. `busy`=1 and `vec`=0 from cycle t+1.
- **Vector timing.** Vector k is driven from cycle t+1+k·(SETTLE+1). It is sampled in cycle t+1+k·(SETTLE+1)+SETTLE, so each vector takes SETTLE+1 cycles.
- **Done.** `done`=1 in cycle t+1+2^N_IN·(SETTLE+1). With the defaults this is t+33. In that cycle `table_out`, `mismatch_cnt`, `first_fail*` and `pass` are final.
- **Earliest restart.** `busy` drops the cycle after `done`. The earliest next accepted `start` is in that cycle.
- **Sampling assumption.** `f_in` is sampled as a combinational function of `vec`. The logic block must settle within SETTLE cycles.
- **Outputs.** All outputs are registered.

## Test plan

- **Reset.** Assert `rst` with clk running -> all outputs 0; `start` held low keeps `busy`=0 indefinitely.
- **Golden block.** Drive `f_in` from the default logic block, `start` at t -> `done` at t+33, `table_out`=16'h0222, `mismatch_cnt`=0, `pass`=1, `first_fail_valid`=0.
- **Stuck-at-0 F.** -> `table_out`=16'h0000, `mismatch_cnt`=3, `first_fail`=1, `pass`=0.
- **Stuck-at-1 F.** -> `table_out`=16'hFFFF, `mismatch_cnt`=13, `first_fail`=0, `pass`=0.
- **Start while busy, and reset mid-scan.**
  - Pulse `start` at t+10 -> ignored; `done` still at t+33.
  - Assert `rst` at t+20 -> no `done`, results 0.
  - A new `start` afterwards yields correct results.
- **SETTLE=3.** Golden block -> `vec` steps every 4 cycles, `done` at t+65, `pass`=1.

Source files
------------

// File: rtl/truth_table_scanner.sv
// Clocked exerciser for small combinational blocks: sweeps every input vector,
// waits SETTLE cycles, captures F and compares the table against EXPECTED.
module truth_table_scanner #(
    parameter int                   N_IN     = 4,
    parameter int                   SETTLE   = 1,
    parameter logic [2**N_IN-1:0]   EXPECTED = 16'h0222
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [N_IN-1:0]     vec,
    input  logic                f_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [2**N_IN-1:0]  table_out,
    output logic [N_IN:0]       mismatch_cnt,
    output logic [N_IN-1:0]     first_fail,
    output logic                first_fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0]      SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_MAX   = {N_IN{1'b1}};

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  cnt_r;
    logic        mismatch_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and compare of the current sample against the golden bit.
    always_comb begin
        state_nxt_s = state_r;
        mismatch_s  = f_in ^ EXPECTED[vec];
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == SETTLE_M1) begin
                    state_nxt_s = ST_SAMPLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_SAMPLE: begin
                if (vec == VEC_MAX) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Status flags decoded from the next state so they are registered and
    // line up exactly with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt_s != ST_IDLE);
            done <= (state_nxt_s == ST_DONE);
        end
    end

    // Scan datapath: vector sequencing, settle timer, capture and scoring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec              <= '0;
            cnt_r            <= 4'd0;
            table_out        <= '0;
            mismatch_cnt     <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        vec              <= '0;
                        cnt_r            <= 4'd0;
                        table_out        <= '0;
                        mismatch_cnt     <= '0;
                        first_fail       <= '0;
                        first_fail_valid <= 1'b0;
                        pass             <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != SETTLE_M1) begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    table_out[vec] <= f_in;
                    if (mismatch_s) begin
                        mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
                        if (!first_fail_valid) begin
                            first_fail       <= vec;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (vec != VEC_MAX) begin
                        vec   <= vec + N_IN'(1);
                        cnt_r <= 4'd0;
                    end else begin
                        // Count must include this final vector's outcome.
                        pass <= (mismatch_cnt == '0) && !mismatch_s;
                    end
                end
                ST_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: golden, stuck-at, start-while-busy,
// mid-scan reset and a SETTLE=3 instance.
module tb_truth_table_scanner;

    logic        clk;
    logic        rst;
    logic        start0, start1;
    logic [1:0]  mode0;
    logic [3:0]  vec0, vec1;
    logic        f0, f1;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic [15:0] table0, table1;
    logic [4:0]  mcnt0, mcnt1;
    logic [3:0]  ff0, ff1;
    logic        ffv0, ffv1;

    int checks;
    int errors;
    int lat;
    int dcount;

    truth_table_scanner #(.N_IN(4), .SETTLE(1), .EXPECTED(16'h0222)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .vec(vec0), .f_in(f0),
        .busy(busy0), .done(done0), .pass(pass0), .table_out(table0),
        .mismatch_cnt(mcnt0), .first_fail(ff0), .first_fail_valid(ffv0)
    );

    truth_table_scanner #(.N_IN(4), .SETTLE(3), .EXPECTED(16'h0222)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .vec(vec1), .f_in(f1),
        .busy(busy1), .done(done1), .pass(pass1), .table_out(table1),
        .mismatch_cnt(mcnt1), .first_fail(ff1), .first_fail_valid(ffv1)
    );

    // Reference block: F = ~(A&B | C) & D, vector is {A,B,C,D}.
    function automatic logic golden(input logic [3:0] v);
        return ~((v[3] & v[2]) | v[1]) & v[0];
    endfunction

    assign f0 = (mode0 == 2'd0) ? golden(vec0) : (mode0 == 2'd1) ? 1'b0 : 1'b1;
    assign f1 = golden(vec1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start a scan on dut0 (sel=0) or dut1 (sel=1) and return cycles from the
    // start cycle to the done cycle; optionally re-pulse start at cycle pulse_at.
    task automatic run_scan(input bit sel, input int pulse_at, output int l);
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        l = 1;
        check("busy_after_start", 32'(sel ? busy1 : busy0), 32'd1);
        check("vec_after_start",  32'(sel ? vec1 : vec0), 32'd0);
        while (l < 200) begin
            if (sel ? done1 : done0) break;
            @(negedge clk);
            l++;
            if (!sel) start0 = (l == pulse_at);
            if (sel && l == 5)  check("s3_vec_at5", 32'(vec1), 32'd1);
            if (sel && l == 9)  check("s3_vec_at9", 32'(vec1), 32'd2);
            if (!sel && l == 3) check("s1_vec_at3", 32'(vec0), 32'd1);
        end
        start0 = 1'b0;
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clk);
        check({tag, "_busy_drop"}, 32'(busy0), 32'd0);
        check({tag, "_done_pulse"}, 32'(done0), 32'd0);
        check({tag, "_vec_hold"}, 32'(vec0), 32'd15);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        mode0  = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_vec",   32'(vec0), 32'd0);
        check("rst_busy",  32'(busy0), 32'd0);
        check("rst_done",  32'(done0), 32'd0);
        check("rst_pass",  32'(pass0), 32'd0);
        check("rst_table", 32'(table0), 32'd0);
        check("rst_mcnt",  32'(mcnt0), 32'd0);
        check("rst_ff",    32'({ffv0, ff0}), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_busy", 32'(busy0), 32'd0);

        // Golden block.
        mode0 = 2'd0;
        run_scan(1'b0, 0, lat);
        check("gold_latency", 32'(lat), 32'd33);
        check("gold_busy_in_done", 32'(busy0), 32'd1);
        check("gold_table", 32'(table0), 32'h0222);
        check("gold_mcnt",  32'(mcnt0), 32'd0);
        check("gold_pass",  32'(pass0), 32'd1);
        check("gold_ffv",   32'(ffv0), 32'd0);
        check_idle_after("gold");
        check("gold_pass_hold", 32'(pass0), 32'd1);

        // Stuck-at-0 F.
        mode0 = 2'd1;
        run_scan(1'b0, 0, lat);
        check("sa0_latency", 32'(lat), 32'd33);
        check("sa0_table", 32'(table0), 32'h0000);
        check("sa0_mcnt",  32'(mcnt0), 32'd3);
        check("sa0_ff",    32'(ff0), 32'd1);
        check("sa0_ffv",   32'(ffv0), 32'd1);
        check("sa0_pass",  32'(pass0), 32'd0);
        check_idle_after("sa0");

        // Stuck-at-1 F, with a start pulse mid-scan that must be ignored.
        mode0 = 2'd2;
        run_scan(1'b0, 10, lat);
        check("sa1_latency", 32'(lat), 32'd33);
        check("sa1_table", 32'(table0), 32'hFFFF);
        check("sa1_mcnt",  32'(mcnt0), 32'd13);
        check("sa1_ff",    32'(ff0), 32'd0);
        check("sa1_ffv",   32'(ffv0), 32'd1);
        check("sa1_pass",  32'(pass0), 32'd0);
        check_idle_after("sa1");

        // Reset mid-scan at cycle t+20.
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (19) @(negedge clk);
        check("mid_busy_before_rst", 32'(busy0), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy",  32'(busy0), 32'd0);
        check("mid_rst_table", 32'(table0), 32'd0);
        check("mid_rst_mcnt",  32'(mcnt0), 32'd0);
        check("mid_rst_vec",   32'(vec0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done0) dcount++;
        end
        check("mid_no_done", 32'(dcount), 32'd0);
        check("mid_idle_busy", 32'(busy0), 32'd0);

        // Fresh scan after abort.
        mode0 = 2'd0;
        run_scan(1'b0, 0, lat);
        check("post_latency", 32'(lat), 32'd33);
        check("post_table", 32'(table0), 32'h0222);
        check("post_pass",  32'(pass0), 32'd1);

        // SETTLE=3 instance.
        run_scan(1'b1, 0, lat);
        check("s3_latency", 32'(lat), 32'd65);
        check("s3_table", 32'(table1), 32'h0222);
        check("s3_mcnt",  32'(mcnt1), 32'd0);
        check("s3_pass",  32'(pass1), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
